// File: rtl/mii_mac_rx.sv
// MII receive-side MAC front end.
// Removes preamble/SFD, packs LSN-first nibbles into bytes, tracks CRC-32 and
// frame length, and emits a byte stream with a status word on the last beat.
// One completed byte is always held back so the final byte of a frame can be
// tagged with out_last/out_status once the carrier drops.
module mii_mac_rx #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       valid,
    input  logic [3:0] data,
    input  logic       err,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic [4:0] out_status,
    output logic       drop
);
    localparam int          LEN_W       = $clog2(MAX_FRAME + 2);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_LO, S_HI, S_DROP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     lo_q, lo_d;
    logic [7:0]     held_q, held_d;
    logic           held_vld_q, held_vld_d;
    logic [31:0]    crc_q, crc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic           phy_q, phy_d;
    // Set when an oversize frame has already produced its last beat, so the
    // trailing DROP state must not also report a drop.
    logic           emitted_q, emitted_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic [4:0]     out_status_q, out_status_d;
    logic           drop_q, drop_d;

    // Reflected CRC-32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    logic [7:0]       new_byte;
    logic [LEN_W-1:0] len_inc;
    assign new_byte = {data, lo_q};
    assign len_inc  = (len_q == LEN_W'(MAX_FRAME + 1)) ? len_q : len_q + 1'b1;

    // Next-state, byte pipeline and output strobes; everything advances only on ce.
    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        held_d       = held_q;
        held_vld_d   = held_vld_q;
        crc_d        = crc_q;
        len_d        = len_q;
        phy_d        = phy_q;
        emitted_d    = emitted_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        out_status_d = 5'b0;
        drop_d       = 1'b0;
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    emitted_d = 1'b0;
                    if (valid) begin
                        state_d = (!err && data == 4'h5) ? S_PRE : S_DROP;
                    end
                end
                S_PRE: begin
                    if (!valid) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b1;
                    end else if (err) begin
                        state_d = S_DROP;
                    end else if (data == 4'hD) begin
                        state_d    = S_LO;
                        crc_d      = CRC_INIT;
                        len_d      = '0;
                        phy_d      = 1'b0;
                        held_vld_d = 1'b0;
                    end else if (data != 4'h5) begin
                        state_d = S_DROP;
                    end
                end
                S_LO, S_HI: begin
                    if (valid) begin
                        if (err) phy_d = 1'b1;
                        if (state_q == S_LO) begin
                            lo_d    = data;
                            state_d = S_HI;
                        end else if (len_q == LEN_W'(MAX_FRAME)) begin
                            // Byte MAX_FRAME+1 completed: close the frame on the held byte.
                            out_valid_d  = 1'b1;
                            out_last_d   = 1'b1;
                            out_data_d   = held_q;
                            out_status_d = {1'b1, 1'b0, 1'b0, 1'b0, phy_q | err};
                            len_d        = len_inc;
                            held_vld_d   = 1'b0;
                            emitted_d    = 1'b1;
                            state_d      = S_DROP;
                        end else begin
                            if (held_vld_q) begin
                                out_valid_d = 1'b1;
                                out_data_d  = held_q;
                            end
                            held_d     = new_byte;
                            held_vld_d = 1'b1;
                            crc_d      = crc_byte(crc_q, new_byte);
                            len_d      = len_inc;
                            state_d    = S_LO;
                        end
                    end else begin
                        // Carrier end: a pending low nibble in HI is discarded.
                        state_d    = S_IDLE;
                        held_vld_d = 1'b0;
                        if (held_vld_q) begin
                            out_valid_d  = 1'b1;
                            out_last_d   = 1'b1;
                            out_data_d   = held_q;
                            out_status_d = {1'b0,
                                            len_q < LEN_W'(MIN_FRAME),
                                            state_q == S_HI,
                                            crc_q != CRC_RESIDUE,
                                            phy_q};
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end
                S_DROP: begin
                    if (!valid) begin
                        state_d = S_IDLE;
                        drop_d  = !emitted_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lo_q         <= 4'h0;
            held_q       <= 8'h00;
            held_vld_q   <= 1'b0;
            crc_q        <= CRC_INIT;
            len_q        <= '0;
            phy_q        <= 1'b0;
            emitted_q    <= 1'b0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_status_q <= 5'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            held_q       <= held_d;
            held_vld_q   <= held_vld_d;
            crc_q        <= crc_d;
            len_q        <= len_d;
            phy_q        <= phy_d;
            emitted_q    <= emitted_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_status_q <= out_status_d;
            drop_q       <= drop_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_status = out_status_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_mii_mac_rx.sv
// Bench for mii_mac_rx: frames are built as byte arrays, sent nibble-wise with
// random ce spacing, and the received beat stream is compared against a
// frame-level model (FCS recomputed from the payload, length and flags).
module tb_mii_mac_rx;
    localparam int MIN_FRAME = 64;
    localparam int MAX_FRAME = 1518;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] data = 4'h0;
    logic       err = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic [4:0] out_status;
    logic       drop;

    mii_mac_rx #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME)) dut (
        .clk(clk), .rst(rst), .ce(ce), .valid(valid), .data(data), .err(err),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_status(out_status), .drop(drop)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        int         cnt;
        int         bad;
        int         last;
        logic [4:0] st;
        int         drops;
        int         proto;
    } res_t;

    int checks = 0;
    int failures = 0;

    // Observed stream.
    logic [7:0] got_data[$];
    logic       got_last[$];
    logic [4:0] got_status[$];
    int         drop_cnt = 0;
    int         proto_viol = 0;
    logic       ce_s = 1'b0;

    always @(posedge clk) ce_s <= ce;

    always @(negedge clk) begin
        if (out_valid) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            got_status.push_back(out_status);
            if (!ce_s) proto_viol++;
        end
        if (out_last && !out_valid) proto_viol++;
        if (!out_last && out_status != 5'b0) proto_viol++;
        if (drop) drop_cnt++;
    end

    function automatic logic [31:0] crc32(bq_t q, int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t rand_bytes(int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic bq_t with_fcs(bq_t p);
        bq_t q;
        logic [31:0] f;
        q = p;
        f = crc32(p, p.size());
        q.push_back(f[7:0]);
        q.push_back(f[15:8]);
        q.push_back(f[23:16]);
        q.push_back(f[31:24]);
        return q;
    endfunction

    // Frame-level expectation: beats = bytes after SFD (capped at MAX_FRAME),
    // status from FCS match, length limits, odd nibble and PHY error.
    function automatic res_t model(bq_t f, bit extra, int err_idx, bit aborted);
        res_t e;
        int   n;
        bit   ok;
        n       = f.size();
        e.bad   = -1;
        e.proto = 0;
        e.drops = 0;
        if (aborted || n == 0) begin
            e.cnt   = 0;
            e.last  = -1;
            e.st    = 5'b0;
            e.drops = 1;
            return e;
        end
        e.cnt  = (n > MAX_FRAME) ? MAX_FRAME : n;
        e.last = e.cnt - 1;
        if (n > MAX_FRAME) begin
            e.st = 5'b10000;
        end else begin
            ok   = (n >= 4) && (crc32(f, n - 4) == {f[n-1], f[n-2], f[n-3], f[n-4]});
            e.st = {1'b0, n < MIN_FRAME, extra, !ok, (err_idx >= 0) && (err_idx < n)};
        end
        return e;
    endfunction

    function automatic res_t observe(bq_t f);
        res_t o;
        o.cnt  = got_data.size();
        o.bad  = -1;
        o.last = -1;
        for (int i = got_data.size() - 1; i >= 0; i--) begin
            if (i < f.size() && got_data[i] !== f[i]) o.bad = i;
            if (got_last[i]) o.last = i;
        end
        o.st    = (got_status.size() > 0) ? got_status[got_status.size()-1] : 5'b0;
        o.drops = drop_cnt;
        o.proto = proto_viol;
        return o;
    endfunction

    function automatic string fmt(res_t r);
        return $sformatf("cnt=%0d bad=%0d last=%0d st=%b drops=%0d proto=%0d",
                         r.cnt, r.bad, r.last, r.st, r.drops, r.proto);
    endfunction

    task automatic clear_obs();
        got_data.delete();
        got_last.delete();
        got_status.delete();
        drop_cnt   = 0;
        proto_viol = 0;
    endtask

    // One nibble with a single ce pulse, then 0..1 idle clocks.
    task automatic send_nib(input logic v, input logic [3:0] d, input logic e);
        valid = v;
        data  = d;
        err   = e;
        ce    = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic send_frame(bq_t f, int npre, bit extra, int err_idx, int n_idle);
        for (int i = 0; i < npre; i++) send_nib(1'b1, 4'h5, 1'b0);
        send_nib(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < f.size(); i++) begin
            send_nib(1'b1, f[i][3:0], i == err_idx);
            send_nib(1'b1, f[i][7:4], 1'b0);
        end
        if (extra) send_nib(1'b1, 4'($urandom), 1'b0);
        for (int i = 0; i < n_idle; i++) send_nib(1'b0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_data, out_valid, out_last, out_status, drop} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0",
                     {out_data, out_valid, out_last, out_status, drop});
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: outputs=%h", {out_data, out_valid, out_last, out_status, drop});
    endtask

    task automatic test_good();
        bq_t  f;
        res_t o, e;
        clear_obs();
        f = with_fcs(rand_bytes(60));
        send_frame(f, 15, 1'b0, -1, 3);
        o = observe(f);
        e = model(f, 1'b0, -1, 1'b0);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL good_frame got %s required %s", fmt(o), fmt(e));
        end
        $display("good_frame: %s", fmt(o));
    endtask

    task automatic test_crc();
        bq_t  f;
        res_t o, e;
        clear_obs();
        f = with_fcs(rand_bytes(60));
        f[10] = f[10] ^ 8'h01;
        send_frame(f, 15, 1'b0, -1, 3);
        o = observe(f);
        e = model(f, 1'b0, -1, 1'b0);
        checks++;
        if (o !== e || o.st !== 5'b00010) begin
            failures++;
            $display("FAIL crc_error got %s required %s", fmt(o), fmt(e));
        end
        $display("crc_error: %s", fmt(o));
    endtask

    task automatic test_align();
        bq_t  f;
        res_t o, e;
        clear_obs();
        f = with_fcs(rand_bytes(60));
        send_frame(f, 15, 1'b1, -1, 3);
        o = observe(f);
        e = model(f, 1'b1, -1, 1'b0);
        checks++;
        if (o !== e || o.st !== 5'b00100) begin
            failures++;
            $display("FAIL align got %s required %s", fmt(o), fmt(e));
        end
        $display("align: %s", fmt(o));
    endtask

    task automatic test_phy();
        bq_t  f;
        res_t o, e;
        clear_obs();
        f = with_fcs(rand_bytes(60));
        send_frame(f, 15, 1'b0, 20, 3);
        o = observe(f);
        e = model(f, 1'b0, 20, 1'b0);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL phy_err got %s required %s", fmt(o), fmt(e));
        end
        $display("phy_err: %s", fmt(o));
    endtask

    task automatic test_bad_preamble();
        bq_t  f;
        res_t o, e;
        // 5,5,3 then data nibbles
        clear_obs();
        send_nib(1'b1, 4'h5, 1'b0);
        send_nib(1'b1, 4'h5, 1'b0);
        send_nib(1'b1, 4'h3, 1'b0);
        for (int i = 0; i < 12; i++) send_nib(1'b1, 4'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) send_nib(1'b0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        o = observe(f);
        e = model(f, 1'b0, -1, 1'b1);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL bad_preamble got %s required %s", fmt(o), fmt(e));
        end
        $display("bad_preamble: %s", fmt(o));
        // carrier drops right after SFD
        clear_obs();
        send_frame(f, 7, 1'b0, -1, 3);
        o = observe(f);
        e = model(f, 1'b0, -1, 1'b0);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL sfd_only got %s required %s", fmt(o), fmt(e));
        end
        $display("sfd_only: %s", fmt(o));
        // first nibble not preamble
        clear_obs();
        send_nib(1'b1, 4'h7, 1'b0);
        send_nib(1'b1, 4'h5, 1'b0);
        send_nib(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < 8; i++) send_nib(1'b1, 4'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) send_nib(1'b0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        o = observe(f);
        e = model(f, 1'b0, -1, 1'b1);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL idle_bad_nibble got %s required %s", fmt(o), fmt(e));
        end
        $display("idle_bad_nibble: %s", fmt(o));
    endtask

    task automatic test_oversize();
        bq_t  f;
        res_t o, e;
        clear_obs();
        f = rand_bytes(1600);
        send_frame(f, 15, 1'b0, -1, 3);
        o = observe(f);
        e = model(f, 1'b0, -1, 1'b0);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL oversize got %s required %s", fmt(o), fmt(e));
        end
        $display("oversize: %s", fmt(o));
    endtask

    task automatic test_reset_mid();
        bq_t  f;
        res_t o, e;
        clear_obs();
        f = rand_bytes(30);
        for (int i = 0; i < 15; i++) send_nib(1'b1, 4'h5, 1'b0);
        send_nib(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < f.size(); i++) begin
            send_nib(1'b1, f[i][3:0], 1'b0);
            send_nib(1'b1, f[i][7:4], 1'b0);
        end
        valid = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_obs();
        for (int i = 0; i < 4; i++) send_nib(1'b0, 4'h0, 1'b0);
        checks++;
        if (got_data.size() !== 0 || drop_cnt !== 0) begin
            failures++;
            $display("FAIL reset_mid_quiet got beats=%0d drops=%0d required 0 0",
                     got_data.size(), drop_cnt);
        end
        f = with_fcs(rand_bytes(70));
        send_frame(f, 15, 1'b0, -1, 3);
        o = observe(f);
        e = model(f, 1'b0, -1, 1'b0);
        checks++;
        if (o !== e || o.st !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_frame got %s required %s", fmt(o), fmt(e));
        end
        $display("reset_mid_frame: %s", fmt(o));
    endtask

    task automatic test_random();
        bq_t  f;
        res_t o, e;
        int   err_idx;
        bit   extra;
        for (int k = 0; k < 8; k++) begin
            clear_obs();
            if (k == 0) f = rand_bytes(0);
            else        f = with_fcs(rand_bytes($urandom_range(0, 96)));
            if (f.size() > 0 && $urandom_range(0, 1) == 1) begin
                int j;
                j    = $urandom_range(0, f.size() - 1);
                f[j] = f[j] ^ (8'h01 << $urandom_range(0, 7));
            end
            err_idx = (f.size() > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, f.size() - 1) : -1;
            extra   = ($urandom_range(0, 2) == 0);
            send_frame(f, $urandom_range(1, 15), extra, err_idx, $urandom_range(1, 3));
            o = observe(f);
            e = model(f, extra, err_idx, 1'b0);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random_%0d got %s required %s", k, fmt(o), fmt(e));
            end
            $display("random_%0d len=%0d: %s", k, f.size(), fmt(o));
        end
    endtask

    task automatic test_back_to_back();
        bq_t  f;
        res_t o, e;
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            f = with_fcs(rand_bytes(64 + k));
            send_frame(f, 2, 1'b0, -1, 1);
            o = observe(f);
            e = model(f, 1'b0, -1, 1'b0);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL back_to_back_%0d got %s required %s", k, fmt(o), fmt(e));
            end
            $display("back_to_back_%0d: %s", k, fmt(o));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good();
        test_crc();
        test_align();
        test_phy();
        test_bad_preamble();
        test_oversize();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
